// File: rtl/memory_writer.sv
// memory_writer: packs a valid/ready pixel stream into a frame-organised
// memory image. Each frame is IN_WIDTH words written at
// frame_count*IN_WIDTH + index. Frames with the wrong length are flagged and
// are not committed. Writing stops once MAX_FRAMES frames have been committed.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          allows stream words to be accepted
//   clear           synchronous restart; empties the frame image count
//   s_valid/s_ready stream handshake (s_ready decoded from state and enable)
//   s_data, s_last  stream word and end-of-frame marker
//   mem_we/mem_addr/mem_wdata  registered memory write port
//   frame_done      one-cycle pulse on a committed frame
//   len_err         one-cycle pulse on a frame length violation
//   frame_count     number of committed frames
//   full            frame_count has reached MAX_FRAMES
module memory_writer #(
    parameter int unsigned IN_WIDTH   = 784,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MAX_FRAMES = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              frame_done,
    output logic              len_err,
    output logic [15:0]       frame_count,
    output logic              full
);

    localparam int unsigned IDX_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_FULL
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    widx;
    logic [IDX_W-1:0]    widx_nxt;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   base_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                full_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                done_nxt;
    logic                lerr_nxt;
    logic                xfer;

    // Ready decode: follows enable while filling, always open while draining
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_FILL:  s_ready = enable;
            ST_DRAIN: s_ready = 1'b1;
            default:  s_ready = 1'b0;
        endcase
    end

    assign xfer = s_valid && s_ready;

    // Next-state, frame bookkeeping and write-port values
    always_comb begin
        state_nxt = state;
        widx_nxt  = widx;
        base_nxt  = base;
        count_nxt = frame_count;
        full_nxt  = full;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        done_nxt  = 1'b0;
        lerr_nxt  = 1'b0;

        if (clear) begin
            // Clear wins over any transfer in the same cycle
            state_nxt = ST_IDLE;
            widx_nxt  = '0;
            base_nxt  = '0;
            count_nxt = '0;
            full_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && !full) begin
                        state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (xfer) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = base + ADDR_W'(widx);
                        wdata_nxt = s_data;
                        if (widx == IDX_W'(IN_WIDTH - 1)) begin
                            widx_nxt = '0;
                            if (s_last) begin
                                // Commit: base advances so the next frame lands after this one
                                done_nxt = 1'b1;
                                base_nxt = base + ADDR_W'(IN_WIDTH);
                                if (frame_count != CNT_W'(MAX_FRAMES)) begin
                                    count_nxt = frame_count + CNT_W'(1);
                                end
                                if (frame_count == CNT_W'(MAX_FRAMES - 1)) begin
                                    full_nxt  = 1'b1;
                                    state_nxt = ST_FULL;
                                end
                            end else begin
                                // Overlong frame: swallow the rest up to s_last
                                lerr_nxt  = 1'b1;
                                state_nxt = ST_DRAIN;
                            end
                        end else if (s_last) begin
                            // Short frame: restart at the same base, overwriting it
                            lerr_nxt = 1'b1;
                            widx_nxt = '0;
                        end else begin
                            widx_nxt = widx + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer && s_last) begin
                        state_nxt = ST_FILL;
                    end
                end
                ST_FULL: begin
                    state_nxt = ST_FULL;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            widx        <= '0;
            base        <= '0;
            frame_count <= '0;
            full        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            frame_done  <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            widx        <= widx_nxt;
            base        <= base_nxt;
            frame_count <= count_nxt;
            full        <= full_nxt;
            mem_we      <= we_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            frame_done  <= done_nxt;
            len_err     <= lerr_nxt;
        end
    end

endmodule
